// File: rtl/ddk_data_rx_pkg.sv
// Shared definitions for the LPC ingress stage: bus width, synchroniser
// depth default and the FIFO entry layout {cmd, data}.
package ddk_data_rx_pkg;

  // Width of the MCU parallel bus.
  localparam int DDK_DW = 16;

  // Default number of synchroniser flops on each asynchronous input.
  localparam int DDK_SYNC_STG = 2;

  // One FIFO entry: command tag plus data word.
  localparam int DDK_ENT_W = DDK_DW + 1;

  typedef struct packed {
    logic              cmd;   // 1 = command word (DataWe was low)
    logic [DDK_DW-1:0] data;
  } ddk_ent_t;

  // Build a FIFO entry from the synchronised write-enable and data word.
  function automatic ddk_ent_t ddk_make_ent(input logic we, input logic [DDK_DW-1:0] d);
    ddk_ent_t ent;
    ent.cmd  = ~we;
    ent.data = d;
    return ent;
  endfunction

endpackage

// File: rtl/ddk_data_rx_fifo.sv
// Single-clock FIFO for the ingress stage. Pointers carry a wrap bit so
// full and empty are distinguished without a separate counter. The head is
// read straight from the storage flops; there is no fall-through path, so a
// word pushed at an edge becomes visible only after that edge.
module ddk_data_rx_fifo
  import ddk_data_rx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  ddk_ent_t  push_ent_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output ddk_ent_t  head_o,
  output logic [AW:0] level_o
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  ddk_ent_t    mem_q [DEPTH];
  logic        pop_ok;
  logic        push_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A pop on an empty FIFO is ignored; a push into a full FIFO is accepted
  // only when a pop frees the head slot in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o = wr_ptr_q - rd_ptr_q;

  // Next-state pointer arithmetic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; a full push with a pop overwrites the slot being read out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is reset on purpose so the head reads zero after reset and stale words never leak.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_ent_i;
    end
  end

endmodule

// File: rtl/ddk_data_rx.sv
// Ingress stage between the LPC parallel bus and ddk_core. Synchronises the
// asynchronous MCU strobe, data and write-enable, detects each DataClk rise
// and pushes one tagged word per rise into a FIFO read by the core over a
// valid/ready stream. Words arriving while the FIFO is full are dropped and
// flagged in a sticky overflow bit.
module ddk_data_rx
  import ddk_data_rx_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int SYNC_STG = DDK_SYNC_STG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DataClk,
  input  logic              DataWe,
  input  logic [DDK_DW-1:0] DATA,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DDK_DW-1:0] out_data,
  output logic              out_cmd,
  output logic [AW:0]       level,
  output logic              overflow,
  input  logic              ovf_clr
);

  // Counter that waits until the synchroniser chain holds real pin samples
  // taken after reset; until then the chain output is only the reset value.
  localparam int                WARM_W    = $clog2(SYNC_STG + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STG);
  localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);

  logic [SYNC_STG-1:0] s_dc_q;
  logic [SYNC_STG-1:0] s_we_q;
  logic [DDK_DW-1:0]   s_d_q [SYNC_STG];
  logic                clk_d_q;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic                armed_q, armed_d;
  logic                ovf_q, ovf_d;

  logic                s_dc_n;
  logic                s_we_n;
  logic [DDK_DW-1:0]   s_d_n;
  logic                warm_done;
  logic                rise;
  logic                pop;
  logic                drop;

  logic                fifo_full;
  logic                fifo_empty;
  ddk_ent_t            fifo_head;

  assign s_dc_n = s_dc_q[SYNC_STG-1];
  assign s_we_n = s_we_q[SYNC_STG-1];
  assign s_d_n  = s_d_q[SYNC_STG-1];

  // Synchroniser chains for the strobe, write-enable and data bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_dc_q <= '0;
      s_we_q <= '0;
      for (int i = 0; i < SYNC_STG; i++) s_d_q[i] <= '0;
    end else begin
      s_dc_q   <= {s_dc_q[SYNC_STG-2:0], DataClk};
      s_we_q   <= {s_we_q[SYNC_STG-2:0], DataWe};
      s_d_q[0] <= DATA;
      for (int i = 1; i < SYNC_STG; i++) s_d_q[i] <= s_d_q[i-1];
    end
  end

  // Warm-up count, arming and sticky overflow next-state logic.
  always_comb begin
    warm_d = warm_q;
    if (warm_q != WARM_DONE) warm_d = warm_q + WARM_ONE;

    // Arm only once a genuine low strobe level has been seen after reset,
    // so a strobe held high across reset release never produces a push.
    armed_d = armed_q | (warm_done & ~s_dc_n);

    // A drop in the same cycle as a clear wins, so no loss goes unreported.
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Edge-detector history, arming, warm-up and overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_d_q <= 1'b0;
      warm_q  <= '0;
      armed_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      clk_d_q <= s_dc_n;
      warm_q  <= warm_d;
      armed_q <= armed_d;
      ovf_q   <= ovf_d;
    end
  end

  assign warm_done = (warm_q == WARM_DONE);
  assign rise      = s_dc_n & ~clk_d_q & armed_q;
  assign pop       = out_valid & out_ready;
  assign drop      = rise & fifo_full & ~pop;

  ddk_data_rx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (rise),
    .push_ent_i (ddk_make_ent(s_we_n, s_d_n)),
    .pop_i      (out_ready),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head),
    .level_o    (level)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_head.data;
  assign out_cmd   = fifo_head.cmd;
  assign overflow  = ovf_q;

endmodule
